// File: rtl/rtc_pkg.sv
// Shared BCD types and helpers for the rtc counter blocks.
package rtc_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    localparam logic [23:0] STOPWATCH_DIGIT_MAX = 24'h595999;

    // Out-of-range preset nibbles (including non-BCD codes) land on the digit's limit.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t value, input bcd_digit_t limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/rtc_bcdchain_if.sv
// Control/data bundle between the tick source, the BCD chain and the display path.
interface rtc_bcdchain_if
    import rtc_pkg::*;
#(
    parameter int NUM_DIGITS = 6
);

    logic                              i_tick;
    logic                              i_countenb;
    logic                              i_countinit;
    logic                              i_latchcount;
    logic                              i_load;
    logic [BCD_DIGIT_W*NUM_DIGITS-1:0] i_loadval;
    logic                              i_dir;
    logic [BCD_DIGIT_W*NUM_DIGITS-1:0] o_count;
    logic [BCD_DIGIT_W*NUM_DIGITS-1:0] o_latched;
    logic                              o_rollover;
    logic                              o_maxtime;

    modport master (
        output i_tick, i_countenb, i_countinit, i_latchcount, i_load, i_loadval, i_dir,
        input  o_count, o_latched, o_rollover, o_maxtime
    );

    modport slave (
        input  i_tick, i_countenb, i_countinit, i_latchcount, i_load, i_loadval, i_dir,
        output o_count, o_latched, o_rollover, o_maxtime
    );

endinterface

// File: rtl/rtc_bcd_digit.sv
// One BCD digit with its own limit; term flags the carry/borrow condition for the next digit.
module rtc_bcd_digit
    import rtc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  bcd_digit_t limit,
    input  logic       step_en,
    input  logic       dir,
    input  logic       load,
    input  bcd_digit_t loadval,
    input  logic       clear,
    output bcd_digit_t value,
    output logic       term
);

    always_comb begin
        term = dir ? (value == '0) : (value == limit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= bcd_clamp(loadval, limit);
        end else if (step_en) begin
            if (term) begin
                value <= dir ? limit : '0;
            end else begin
                value <= dir ? (value - 4'd1) : (value + 4'd1);
            end
        end
    end

endmodule

// File: rtl/rtc_bcdchain.sv
// Synchronous N-digit BCD chain with preset, lap snapshot and wrap/saturate terminal handling.
// Down-counting via i_dir is compiled in only when RTC_BCDCHAIN_DOWNCOUNT_EN is defined.
module rtc_bcdchain
    import rtc_pkg::*;
#(
    parameter int                          NUM_DIGITS = 6,
    parameter logic [4*NUM_DIGITS-1:0]     DIGIT_MAX  = STOPWATCH_DIGIT_MAX,
    parameter bit                          SATURATE   = 1'b0
) (
    input  logic          i_rtcclk,
    input  logic          i_reset,
    rtc_bcdchain_if.slave bus
);

    localparam int CW = BCD_DIGIT_W * NUM_DIGITS;

    logic                  step;
    logic                  dir_eff;
    logic                  all_term;
    logic                  hold_term;
    logic                  term_step;
    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS-1:0] term;
    logic [NUM_DIGITS-1:0] step_en;
    bcd_digit_t            digit_val [NUM_DIGITS];
    logic [CW-1:0]         count_w;
    logic [CW-1:0]         latched_q;
    logic                  rollover_q;
    logic                  maxtime_q;

`ifdef RTC_BCDCHAIN_DOWNCOUNT_EN
    assign dir_eff = bus.i_dir;
`else
    logic unused_dir;
    assign unused_dir = bus.i_dir;
    assign dir_eff    = 1'b0;
`endif

    assign step = bus.i_tick & bus.i_countenb;

    // A digit moves only when every lower digit sits at its terminal value.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            carry[k+1] = carry[k] & term[k];
        end
    end

    assign all_term  = carry[NUM_DIGITS];
    assign hold_term = SATURATE & all_term;
    assign term_step = step & all_term & ~bus.i_countinit & ~bus.i_load;

    always_comb begin
        step_en = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            step_en[k] = step & carry[k] & ~hold_term;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        rtc_bcd_digit u_digit (
            .clk     (i_rtcclk),
            .reset   (i_reset),
            .limit   (DIGIT_MAX[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .step_en (step_en[k]),
            .dir     (dir_eff),
            .load    (bus.i_load),
            .loadval (bus.i_loadval[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .clear   (bus.i_countinit),
            .value   (digit_val[k]),
            .term    (term[k])
        );
    end

    always_comb begin
        count_w = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            count_w[k*BCD_DIGIT_W +: BCD_DIGIT_W] = digit_val[k];
        end
    end

    // Snapshot takes the pre-edge count; countinit deliberately leaves the lap value alone.
    always_ff @(posedge i_rtcclk) begin
        if (i_reset) begin
            latched_q  <= '0;
            rollover_q <= 1'b0;
            maxtime_q  <= 1'b0;
        end else begin
            rollover_q <= term_step;
            if (bus.i_countinit || bus.i_load) begin
                maxtime_q <= 1'b0;
            end else if (term_step) begin
                maxtime_q <= 1'b1;
            end
            if (bus.i_latchcount) begin
                latched_q <= count_w;
            end
        end
    end

    assign bus.o_count    = count_w;
    assign bus.o_latched  = latched_q;
    assign bus.o_rollover = rollover_q;
    assign bus.o_maxtime  = maxtime_q;

endmodule

// File: tb/tb_rtc_bcdchain.sv
// Scoreboard bench: wrap (dut0) and saturate (dut1) chains share one directed stimulus stream.
module tb_rtc_bcdchain;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rtc_bcdchain_if #(.NUM_DIGITS(6)) bus0 ();
    rtc_bcdchain_if #(.NUM_DIGITS(6)) bus1 ();

    rtc_bcdchain #(.NUM_DIGITS(6), .DIGIT_MAX(24'h595999), .SATURATE(1'b0)) dut0 (
        .i_rtcclk (clk),
        .i_reset  (rst),
        .bus      (bus0.slave)
    );

    rtc_bcdchain #(.NUM_DIGITS(6), .DIGIT_MAX(24'h595999), .SATURATE(1'b1)) dut1 (
        .i_rtcclk (clk),
        .i_reset  (rst),
        .bus      (bus1.slave)
    );

    typedef struct {
        string       name;
        logic [23:0] c0;
        logic [23:0] c1;
        logic [23:0] lat;
        logic        ro;
        logic        mx;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic tick, input logic enb, input logic init,
                         input logic latch, input logic ld, input logic [23:0] lv, input logic dir);
        @(negedge clk);
        rst               = r;
        bus0.i_tick       = tick;  bus1.i_tick       = tick;
        bus0.i_countenb   = enb;   bus1.i_countenb   = enb;
        bus0.i_countinit  = init;  bus1.i_countinit  = init;
        bus0.i_latchcount = latch; bus1.i_latchcount = latch;
        bus0.i_load       = ld;    bus1.i_load       = ld;
        bus0.i_loadval    = lv;    bus1.i_loadval    = lv;
        bus0.i_dir        = dir;   bus1.i_dir        = dir;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic [23:0] c0, input logic [23:0] c1,
                        input logic [23:0] lat, input logic ro, input logic mx);
        exp_t e;
        e.name = nm; e.c0 = c0; e.c1 = c1; e.lat = lat; e.ro = ro; e.mx = mx;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            chk({cur.name, " count_wrap"},    bus0.o_count,           cur.c0);
            chk({cur.name, " count_sat"},     bus1.o_count,           cur.c1);
            chk({cur.name, " latched_wrap"},  bus0.o_latched,         cur.lat);
            chk({cur.name, " latched_sat"},   bus1.o_latched,         cur.lat);
            chk({cur.name, " rollover_wrap"}, {23'd0, bus0.o_rollover}, {23'd0, cur.ro});
            chk({cur.name, " rollover_sat"},  {23'd0, bus1.o_rollover}, {23'd0, cur.ro});
            chk({cur.name, " maxtime_wrap"},  {23'd0, bus0.o_maxtime},  {23'd0, cur.mx});
            chk({cur.name, " maxtime_sat"},   {23'd0, bus1.o_maxtime},  {23'd0, cur.mx});
        end
    end

    initial begin
        logic [23:0] b;
        drive(1, 0, 0, 0, 0, 0, 24'h0, 0);
        drive(1, 0, 0, 0, 0, 0, 24'h0, 0);
        push("reset", 24'h0, 24'h0, 24'h0, 0, 0);

        for (int i = 1; i <= 10; i++) begin
            drive(0, 1, 1, 0, 0, 0, 24'h0, 0);
            b = 24'((i / 10) * 16 + (i % 10));
            push("count_up", b, b, 24'h0, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 0, 0, 24'h0, 0);
            push("enb_low", 24'h000010, 24'h000010, 24'h0, 0, 0);
        end

        drive(0, 0, 0, 0, 0, 1, 24'h000999, 0);
        push("load_999", 24'h000999, 24'h000999, 24'h0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 24'h0, 0);
        push("carry_1000", 24'h001000, 24'h001000, 24'h0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 24'h005999, 0);
        push("load_5999", 24'h005999, 24'h005999, 24'h0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 24'h0, 0);
        push("carry_10000", 24'h010000, 24'h010000, 24'h0, 0, 0);

        drive(0, 0, 0, 0, 0, 1, 24'h595999, 0);
        push("load_max", 24'h595999, 24'h595999, 24'h0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 24'h0, 0);
        push("terminal", 24'h000000, 24'h595999, 24'h0, 1, 1);
        drive(0, 0, 1, 0, 0, 0, 24'h0, 0);
        push("rollover_one_cycle", 24'h000000, 24'h595999, 24'h0, 0, 1);

        drive(0, 1, 1, 0, 0, 1, 24'h000123, 0);
        push("load_beats_tick", 24'h000123, 24'h000123, 24'h0, 0, 0);
        drive(0, 1, 1, 0, 1, 0, 24'h0, 0);
        push("latch_pre_edge", 24'h000124, 24'h000124, 24'h000123, 0, 0);

        drive(0, 0, 0, 0, 0, 1, 24'hFF00AB, 0);
        push("load_clamp", 24'h590099, 24'h590099, 24'h000123, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 24'h595999, 0);
        push("reload_max", 24'h595999, 24'h595999, 24'h000123, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 24'h0, 0);
        push("terminal2", 24'h000000, 24'h595999, 24'h000123, 1, 1);
        drive(0, 1, 1, 1, 0, 1, 24'h000555, 0);
        push("init_priority", 24'h000000, 24'h000000, 24'h000123, 0, 0);

        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, 1, 0, 0, 0, 24'h0, 0);
            push("recount", 24'(i), 24'(i), 24'h000123, 0, 0);
        end
        drive(1, 1, 1, 0, 1, 0, 24'h0, 0);
        push("reset_mid", 24'h0, 24'h0, 24'h0, 0, 0);

`ifdef RTC_BCDCHAIN_DOWNCOUNT_EN
        drive(0, 0, 0, 0, 0, 1, 24'h010000, 1);
        push("down_load", 24'h010000, 24'h010000, 24'h0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 24'h0, 1);
        push("down_borrow", 24'h005999, 24'h005999, 24'h0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 24'h000000, 1);
        push("down_load_zero", 24'h000000, 24'h000000, 24'h0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 24'h0, 1);
        push("down_terminal", 24'h595999, 24'h000000, 24'h0, 1, 1);
        drive(0, 0, 1, 0, 0, 0, 24'h0, 1);
        push("down_rollover_one_cycle", 24'h595999, 24'h000000, 24'h0, 0, 1);
`endif

        drive(0, 0, 0, 0, 0, 0, 24'h0, 0);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
